// File: rtl/sim_ddr_burst.sv
// Simulation/FPGA-BRAM stand-in for the external DDR: burst command interface,
// byte-enabled write bursts and fixed-latency read bursts with a last-beat flag.
module sim_ddr_burst #(
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 32,
    parameter int DepthWords  = 256,
    parameter int ReadLatency = 16,
    parameter int MaxLen      = 8,
    localparam int LenWidth   = (MaxLen > 1) ? $clog2(MaxLen) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [AddrWidth-1:0]   cmd_addr_i,
    input  logic [LenWidth-1:0]    cmd_len_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [DataWidth-1:0]   wr_data_i,
    input  logic [DataWidth/8-1:0] byte_en_i,
    output logic [DataWidth-1:0]   rd_data_o,
    output logic                   rd_valid_o,
    output logic                   rd_last_o,
    output logic                   err_unaligned_o
);

    localparam int ByteLanes = DataWidth / 8;
    localparam int OffBits   = $clog2(ByteLanes);
    localparam int IdxWidth  = $clog2(DepthWords);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    logic [1:0]           state_r;
    logic [1:0]           state_next_s;
    logic [IdxWidth-1:0]  base_r;
    logic [LenWidth-1:0]  len_r;
    logic [LenWidth-1:0]  beat_r;
    logic                 err_r;
    logic [DataWidth-1:0] mem_r [DepthWords];

    logic                 cmd_fire_s;
    logic                 wr_fire_s;
    logic                 issue_s;
    logic                 last_beat_s;
    logic [IdxWidth-1:0]  word_s;

    logic [ReadLatency-1:0] pipe_valid_r;
    logic [ReadLatency-1:0] pipe_last_r;
    logic [DataWidth-1:0]   pipe_data_r [ReadLatency];
    logic                   rd_valid_r;
    logic                   rd_last_r;
    logic [DataWidth-1:0]   rd_data_r;

    assign cmd_ready_o     = (state_r == IDLE);
    assign wr_ready_o      = (state_r == WRITE);
    assign cmd_fire_s      = cmd_valid_i & cmd_ready_o;
    assign wr_fire_s       = wr_valid_i & wr_ready_o;
    assign issue_s         = (state_r == READ);
    assign last_beat_s     = (beat_r == len_r);
    assign word_s          = base_r + IdxWidth'(beat_r);
    assign rd_valid_o      = rd_valid_r;
    assign rd_last_o       = rd_last_r;
    assign rd_data_o       = rd_data_r;
    assign err_unaligned_o = err_r;

    // Next-state decode of the burst FSM
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_fire_s) begin
                    state_next_s = cmd_write_i ? WRITE : READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                if (wr_fire_s && last_beat_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WRITE;
                end
            end
            READ: begin
                if (last_beat_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = READ;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Command capture, beat counting and the sticky unaligned flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            base_r  <= {IdxWidth{1'b0}};
            len_r   <= {LenWidth{1'b0}};
            beat_r  <= {LenWidth{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (cmd_fire_s) begin
                // Low offset bits are dropped: the burst still runs word-aligned.
                base_r <= cmd_addr_i[IdxWidth+OffBits-1:OffBits];
                len_r  <= cmd_len_i;
                beat_r <= {LenWidth{1'b0}};
                if (cmd_addr_i[OffBits-1:0] != {OffBits{1'b0}}) begin
                    err_r <= 1'b1;
                end
            end else if (wr_fire_s || issue_s) begin
                beat_r <= beat_r + LenWidth'(1'b1);
            end
        end
    end

    // Storage has no reset so contents survive a reset pulse
    always_ff @(posedge clk_i) begin
        if (wr_fire_s) begin
            for (int b = 0; b < ByteLanes; b++) begin
                if (byte_en_i[b]) begin
                    mem_r[word_s][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    // Read latency pipeline plus registered output stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_valid_r <= {ReadLatency{1'b0}};
            pipe_last_r  <= {ReadLatency{1'b0}};
            for (int i = 0; i < ReadLatency; i++) begin
                pipe_data_r[i] <= {DataWidth{1'b0}};
            end
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            rd_data_r  <= {DataWidth{1'b0}};
        end else begin
            pipe_valid_r <= {pipe_valid_r[ReadLatency-2:0], issue_s};
            pipe_last_r  <= {pipe_last_r[ReadLatency-2:0], issue_s & last_beat_s};
            // Bubbles carry zero data so the output is zero whenever invalid.
            pipe_data_r[0] <= issue_s ? mem_r[word_s] : {DataWidth{1'b0}};
            for (int i = 1; i < ReadLatency; i++) begin
                pipe_data_r[i] <= pipe_data_r[i-1];
            end
            rd_valid_r <= pipe_valid_r[ReadLatency-1];
            rd_last_r  <= pipe_last_r[ReadLatency-1];
            rd_data_r  <= pipe_data_r[ReadLatency-1];
        end
    end

endmodule

// File: tb/tb_sim_ddr_burst.sv
// Scoreboard bench for sim_ddr_burst: stimulus pushes expected read beats with
// their arrival cycle; an independent monitor pops and compares them.
module tb_sim_ddr_burst;

    localparam int RL = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic [7:0]  byte_en;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        err_unaligned;

    sim_ddr_burst dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .byte_en_i(byte_en),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_last_o(rd_last),
        .err_unaligned_o(err_unaligned)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [63:0] hand[8];
    logic [63:0] wdata[8];
    logic [7:0]  wbe[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every cycle either a scoreboard beat or a clean idle output
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: rd_valid_o=1 data %h, none expected (cycle %0d)", rd_data, cyc);
            end else begin
                e = sb.pop_front();
                check("rd_cycle", 64'(cyc), 64'(e.cyc));
                check("rd_data", rd_data, e.data);
                check("rd_last", 64'(rd_last), 64'(e.last));
            end
        end else begin
            check("idle_data", rd_data, 64'h0);
            check("idle_last", 64'(rd_last), 64'h0);
        end
    end

    task automatic cmd_issue(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                             output int t);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL cmd_timeout: cmd_ready_o=%b want 1 within 100 cycles", cmd_ready);
        end
        t = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [31:0] addr, input int n, input int stall_at);
        int t;
        int w;
        cmd_issue(1'b1, addr, 3'(n - 1), t);
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                wr_valid = 1'b0;
                @(negedge clk);
            end
            wr_valid = 1'b1;
            wr_data  = wdata[k];
            byte_en  = wbe[k];
            w = 0;
            while (wr_ready !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (wr_ready !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL wr_timeout: wr_ready_o=%b want 1 within 100 cycles", wr_ready);
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    task automatic rd_burst(input logic [31:0] addr, input logic [2:0] len, input bit push,
                            output int t);
        cmd_issue(1'b0, addr, len, t);
        if (push) begin
            for (int k = 0; k <= int'(len); k++) begin
                sb.push_back('{data: hand[k], last: (k == int'(len)), cyc: t + 1 + k + RL});
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats outstanding want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 3'd0;
        wr_valid = 1'b0; wr_data = 64'h0; byte_en = 8'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        check("rst_wr_ready", 64'(wr_ready), 64'h0);
        check("rst_rd_valid", 64'(rd_valid), 64'h0);
        check("rst_rd_last", 64'(rd_last), 64'h0);
        check("rst_rd_data", rd_data, 64'h0);
        check("rst_err", 64'(err_unaligned), 64'h0);
        @(negedge clk);

        // Single write then read, latency checked by monitor
        wdata[0] = 64'h1122334455667788; wbe[0] = 8'hFF;
        wr_burst(32'h40, 1, -1);
        hand[0] = 64'h1122334455667788;
        rd_burst(32'h40, 3'd0, 1'b1, t1);
        wait_drain();

        // Byte enables over a preloaded word
        wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF; wbe[0] = 8'hFF;
        wr_burst(32'h0, 1, -1);
        wdata[0] = 64'h0; wbe[0] = 8'h0F;
        wr_burst(32'h0, 1, -1);
        hand[0] = 64'hFFFF_FFFF_0000_0000;
        rd_burst(32'h0, 3'd0, 1'b1, t1);
        wait_drain();

        // Four-beat write wrapping past the top word, one stall before beat 2
        for (int k = 0; k < 4; k++) begin
            wdata[k] = 64'(k + 1);
            wbe[k]   = 8'hFF;
        end
        wr_burst(32'h7F0, 4, 2);
        hand[0] = 64'd1; hand[1] = 64'd2; hand[2] = 64'd3; hand[3] = 64'd4;
        rd_burst(32'h7F0, 3'd3, 1'b1, t1);
        wait_drain();
        hand[0] = 64'd3; hand[1] = 64'd4;
        rd_burst(32'h0, 3'd1, 1'b1, t1);
        wait_drain();

        // Back-to-back read bursts: single idle cycle between commands
        hand[0] = 64'd1; hand[1] = 64'd2;
        rd_burst(32'h7F0, 3'd1, 1'b1, t1);
        hand[0] = 64'd3; hand[1] = 64'd4;
        rd_burst(32'h0, 3'd1, 1'b1, t2);
        check("b2b_cmd_gap", 64'(t2 - t1), 64'd3);
        wait_drain();

        // Unaligned read: flag rises after the handshake edge and sticks
        check("err_before", 64'(err_unaligned), 64'h0);
        hand[0] = 64'h1122334455667788;
        rd_burst(32'h43, 3'd0, 1'b1, t1);
        check("err_set", 64'(err_unaligned), 64'h1);
        wait_drain();
        repeat (5) @(negedge clk);
        check("err_sticky", 64'(err_unaligned), 64'h1);

        // Asynchronous reset five cycles into a long read burst
        rd_burst(32'h40, 3'd7, 1'b0, t1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'h1);
        check("mid_rst_rd_valid", 64'(rd_valid), 64'h0);
        check("mid_rst_err", 64'(err_unaligned), 64'h0);
        check("mid_rst_wr_ready", 64'(wr_ready), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        hand[0] = 64'h1122334455667788;
        rd_burst(32'h40, 3'd0, 1'b1, t1);
        wait_drain();
        hand[0] = 64'd1; hand[1] = 64'd2; hand[2] = 64'd3; hand[3] = 64'd4;
        rd_burst(32'h7F0, 3'd3, 1'b1, t1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sim_ddr_burst.md
# sim_ddr_burst

Parametrised simulation model of a DDR memory behind a burst command interface. It generalises the team's fixed 64-bit simulated DDR with configurable data width, depth and read latency. It adds a valid/ready command handshake, multi-beat read and write bursts, a last-beat flag and a sticky unaligned-access flag. It sits behind the accelerator's memory arbiter in simulation and FPGA-BRAM builds, standing in for the external DDR controller.

## Interface
- DataWidth, 64, data bus width in bits; multiple of 8, ≥16
- AddrWidth, 32, byte address width
- DepthWords, 256, number of DataWidth-bit words; power of 2
- ReadLatency, 16, cycles from read-beat issue to rd_valid_o; ≥2
- MaxLen, 8, maximum beats per burst; cmd_len_i width = clog2(MaxLen)

- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_write_i  in  1  1 = write burst, 0 = read burst
- cmd_addr_i  in  AddrWidth  byte address of first beat
- cmd_len_i  in  clog2(MaxLen)  beats minus one
- wr_valid_i  in  1  write beat present
- wr_ready_o  out  1  write beat accepted when valid & ready
- wr_data_i  in  DataWidth  write beat data
- byte_en_i  in  DataWidth/8  per-byte write enable for the current beat
- rd_data_o  out  DataWidth  read beat data
- rd_valid_o  out  1  rd_data_o valid this cycle
- rd_last_o  out  1  final beat of a read burst, qualified by rd_valid_o
- err_unaligned_o  out  1  sticky, an unaligned command was accepted

## Operation
- Word index = cmd_addr_i[clog2(DepthWords)+OB-1 : OB], where OB = clog2(DataWidth/8). Upper address bits are ignored, so addresses wrap modulo DepthWords.
- FSM states:
  - IDLE: cmd_ready_o=1. On handshake, latch word index, length and direction, then go to WRITE or READ.
  - WRITE: wr_ready_o=1, cmd_ready_o=0.
    - Each wr_valid_i beat writes the bytes with byte_en_i set to word (base+beat) mod DepthWords, then increments the beat counter.
    - After beat len, return to IDLE.
    - wr_valid_i low stalls with no write.
  - READ: cmd_ready_o=0. Issues one beat per cycle, reading word (base+beat) mod DepthWords into the latency pipeline. After issuing beat len, return to IDLE.
- Read pipeline:
  - ReadLatency stages carry {valid, last, data}; there is no back-pressure.
  - Bubbles travel with valid=0.
  - rd_data_o is 0 whenever rd_valid_o=0.
- Memory is write-first. A read issued any cycle after a write beat's handshake returns the new data.
- Unaligned access: if cmd_addr_i[OB-1:0] ≠ 0 at handshake, err_unaligned_o sets on the next edge and stays set until reset. The command still executes with the low bits dropped.
- wr_valid_i outside WRITE is ignored (wr_ready_o=0). cmd_valid_i outside IDLE waits.

## Timing
- Reset values: cmd_ready_o=1 (IDLE), wr_ready_o=0, rd_valid_o=0, rd_last_o=0, rd_data_o=0, err_unaligned_o=0.
- Reset clears the FSM and every pipeline valid bit; memory contents are preserved.
- Reset mid-burst abandons the burst. Beats already written remain; in-flight read beats never appear.
- Read command handshake at edge T:
  - Beat k is issued at edge T+1+k.
  - Beat k is presented with rd_valid_o=1 in the cycle after edge T+1+k+ReadLatency.
  - Beats are back-to-back; rd_last_o accompanies beat len.
- Throughput limits:
  - cmd_ready_o returns high in the cycle after the last read beat issues, so the minimum gap between read commands is one IDLE cycle.
  - Pipeline output from consecutive read bursts may be separated by that single bubble only.
- Write beat k is committed at its handshake edge. cmd_ready_o goes high in the cycle after the handshake of beat len.

## Test plan
- Single write, then read (DataWidth=64): write 0x1122334455667788 to addr 0x40 with byte_en=0xFF, then read at 0x40 with len=0. rd_valid_o=1 with that data and rd_last_o=1 exactly ReadLatency+1 cycles after the read handshake.
- Byte enables: preload 0xFFFF_FFFF_FFFF_FFFF at addr 0, write 0 with byte_en=0x0F, then read. Returns 0xFFFFFFFF00000000.
- Burst with wrap (DepthWords=256): write 4 beats 1,2,3,4 at byte addr 0x7F0 (word 254), inserting one wr_valid_i=0 stall. A read burst of len=3 at 0x7F0 returns 1,2,3,4 on consecutive cycles, and words 0 and 1 hold 3 and 4.
- Back-to-back reads: two read commands of len=1 issued as fast as cmd_ready_o allows. Four valid beats arrive with exactly one bubble between the bursts, and rd_last_o is set on beats 2 and 4.
- Unaligned access: a read at 0x43 sets err_unaligned_o one cycle later, returns the data of word 8, and the flag stays high until rst_i.
- Reset mid-read: assert rst_i asynchronously 5 cycles into a len=7 read burst. rd_valid_o stays 0 afterwards, cmd_ready_o=1 immediately, and earlier-written memory contents read back unchanged.
